spi_cmd_master: RTL and testbench

SPI master that drives the MCU-side command link of the display/PWM/frequency-meter slave from inside the FPGA fabric. It serializes 16-bit write frames (address byte + data byte) and 8-bit query frames followed by a 32-bit read-back, using mode 0 (CPOL=0, CPHA=0) with MSB first. It sits between an internal request/response port, used by a sequencer or soft-CPU bridge, and the four SPI pins.

---
 rtl/spi_cmd_master.sv | 140 ++++++++++++++
 tb/tb_spi_cmd_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: 16-bit write frames and 8-bit query frames with a
// 32-bit read-back. spi_out is synchronised before use; all outputs are registered.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV = 24,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk,
  output logic        cs,
  output logic        spi_date,
  input  logic        spi_out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  fall_q, fall_d;
  logic        read_q, read_d;
  logic [39:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rsp_q, rsp_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic [1:0]  miso_sync_q;
  logic [5:0]  last_fall;

  assign last_fall = read_q ? 6'd40 : 6'd16;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fall_d      = fall_q;
    read_d      = read_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SHIFT;
          cnt_d   = DIV_LAST;
          fall_d  = '0;
          read_d  = req_read;
          // Frames are left-aligned so the MSB always sits at tx_q[39].
          tx_d    = req_read ? {req_addr, 32'h0} : {req_addr, req_data, 24'h0};
          rx_d    = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d  = DIV_LAST;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            tx_d   = {tx_q[38:0], 1'b0};
            fall_d = fall_q + 6'd1;
            // Read-back starts on the 9th falling edge, after the command byte.
            if (read_q && fall_q >= 6'd8) rx_d = {rx_q[30:0], miso_sync_q[1]};
            if (fall_q + 6'd1 == last_fall) state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LAST;
          cs_d    = 1'b1;
          if (read_q) begin
            rsp_d       = rx_q;
            rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fall_q      <= '0;
      read_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      miso_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
      read_q      <= read_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      miso_sync_q <= {miso_sync_q[0], spi_out};
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign req_ready = ~busy;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q;
  assign spi_clk   = sclk_q;
  assign cs        = cs_q;
  assign spi_date  = tx_q[39];

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: a timing-formula model checked every cycle, an SPI
// slave model, and directed frames with hand-computed expectations.
module tb_spi_cmd_master;
  localparam int D = 24;
  localparam int G = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        req_ready, rsp_valid, busy, spi_clk, cs, spi_date;
  logic [31:0] rsp_data;
  logic        spi_out = 1'b0;

  logic        req_valid4 = 1'b0;
  logic [7:0]  req_addr4 = '0;
  logic [7:0]  req_data4 = '0;
  logic        req_ready4, rsp_valid4, busy4, spi_clk4, cs4, spi_date4;
  logic [31:0] rsp_data4;

  spi_cmd_master #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .spi_clk(spi_clk), .cs(cs), .spi_date(spi_date), .spi_out(spi_out)
  );

  spi_cmd_master #(.CLK_DIV(4), .CS_GAP(8)) u_dut4 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_read(1'b0), .req_addr(req_addr4), .req_data(req_data4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .busy(busy4),
    .spi_clk(spi_clk4), .cs(cs4), .spi_date(spi_date4), .spi_out(1'b0)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI slave model (main DUT) ----------------
  typedef struct { int edges; logic [63:0] bits; } rec_t;
  rec_t        recq[$];
  int          fid = 0, sl_fid = 0, sl_edges = 0;
  logic [63:0] sl_bits = '0;
  logic [31:0] sl_word = '0;

  always @(negedge cs) fid++;

  always @(posedge spi_clk) begin
    if (sl_fid != fid) begin
      sl_fid   = fid;
      sl_edges = 0;
      sl_bits  = '0;
    end
    sl_edges++;
    sl_bits = {sl_bits[62:0], spi_date};
    if (sl_edges >= 9 && sl_edges <= 40) spi_out = sl_word[40 - sl_edges];
    else spi_out = 1'b0;
  end

  always @(posedge cs) begin
    rec_t r;
    r.edges = sl_edges;
    r.bits  = sl_bits;
    recq.push_back(r);
  end

  // ---------------- Timing model ----------------
  int          ecount = 0;
  bit          m_active = 1'b0;
  int          m_a = 0, m_n = 16;
  bit          m_read = 1'b0;
  logic [39:0] m_tx = '0;
  logic [31:0] m_word = '0, m_rsp = '0;

  always @(posedge CLK) begin
    int x, cp;
    bit bz;
    x  = ecount;
    cp = x - m_a;
    bz = m_active && cp <= (2 * m_n + 1) * D + G;
    if (RST) begin
      m_active = 1'b0;
      m_rsp    = '0;
    end else begin
      if (m_active && m_read && cp == (2 * m_n + 1) * D) m_rsp = m_word;
      if (req_valid && !bz) begin
        m_active = 1'b1;
        m_a      = x;
        m_read   = req_read;
        m_n      = req_read ? 40 : 16;
        m_tx     = req_read ? {req_addr, 32'h0} : {req_addr, req_data, 24'h0};
        m_word   = sl_word;
      end
    end
    ecount = x + 1;
  end

  bit checking = 1'b0;
  logic prev_cs = 1'b1;
  int cs_rise_c = -1, cs_fall_c = -1, rv_c = -1, rv_count = 0, hi_run = 0, last_run = -1;

  always @(negedge CLK) begin
    int c, te, j;
    logic e_cs, e_sclk, e_date, e_busy, e_rv;
    if (checking) begin
      c      = ecount - m_a;
      te     = (2 * m_n + 1) * D;
      e_busy = m_active && c >= 1 && c <= te + G;
      e_cs   = !(m_active && c >= 1 && c <= te);
      e_sclk = m_active && c >= 1 && c <= 2 * m_n * D && (((c - 1) / D) % 2 == 1);
      e_date = 1'b0;
      if (m_active && c >= 1 && c <= te) begin
        j = (c - 1) / (2 * D);
        if (j < 40) e_date = m_tx[39 - j];
      end
      e_rv = m_active && m_read && c == te + 1;
      check("cs", 64'(cs), 64'(e_cs));
      check("spi_clk", 64'(spi_clk), 64'(e_sclk));
      check("spi_date", 64'(spi_date), 64'(e_date));
      check("busy", 64'(busy), 64'(e_busy));
      check("req_ready", 64'(req_ready), 64'(!e_busy));
      check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      check("rsp_data", 64'(rsp_data), 64'(m_rsp));
      if (!prev_cs && cs) cs_rise_c = c;
      if (prev_cs && !cs) begin
        cs_fall_c = c;
        last_run  = hi_run;
      end
      if (cs) hi_run++;
      else hi_run = 0;
      if (rsp_valid) begin
        rv_count++;
        rv_c = c;
      end
      prev_cs = cs;
    end
  end

  // ---------------- CLK_DIV=4 instance monitors ----------------
  int          cnt4 = 0, tog4 = 0, hp4 = 0;
  logic [15:0] bits4 = '0;
  logic        prev_cs4 = 1'b1, prev_sclk4 = 1'b0;

  always @(posedge spi_clk4) begin
    cnt4++;
    bits4 = {bits4[14:0], spi_date4};
  end

  always @(negedge CLK) begin
    if (checking) begin
      if (prev_cs4 && !cs4) hp4 = 0;
      else begin
        hp4++;
        if (spi_clk4 !== prev_sclk4) begin
          check("half_period4", 64'(hp4), 64'd4);
          tog4++;
          hp4 = 0;
        end
      end
      prev_cs4   = cs4;
      prev_sclk4 = spi_clk4;
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: req_ready=0 after 6000 cycles, required 1", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: busy=1 after 6000 cycles, required 0", name);
    end
  endtask

  task automatic send(input logic rd, input logic [7:0] a, input logic [7:0] d);
    wait_ready("send_ready");
    req_valid = 1'b1;
    req_read  = rd;
    req_addr  = a;
    req_data  = d;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic check_rec(input string name, input int edges, input logic [63:0] bits);
    rec_t r;
    if (recq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame captured, required %0d edges bits=%0h", name, edges, bits);
    end else begin
      r = recq.pop_front();
      check({name, "_edges"}, 64'(r.edges), 64'(edges));
      check({name, "_bits"}, r.bits, bits);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int rv0;
    repeat (3) @(negedge CLK);
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_spi_clk", 64'(spi_clk), 64'd0);
    check("rst_spi_date", 64'(spi_date), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    RST = 1'b0;
    checking = 1'b1;
    recq.delete();

    // Write 0x00/0x25
    rv_count = 0;
    send(1'b0, 8'h00, 8'h25);
    wait_idle("w25_idle");
    check_rec("w25", 16, 64'h0025);
    check("w25_cs_fall", 64'(cs_fall_c), 64'd1);
    check("w25_cs_rise", 64'(cs_rise_c), 64'd793);
    check("w25_no_rsp", 64'(rv_count), 64'd0);

    // Query 0xBF returning 0x12345678
    sl_word = 32'h12345678;
    rv_count = 0;
    send(1'b1, 8'hBF, 8'h00);
    wait_idle("qbf_idle");
    check_rec("qbf", 40, 64'h000000BF_00000000);
    check("qbf_cs_rise", 64'(cs_rise_c), 64'd1945);
    check("qbf_rsp_cycle", 64'(rv_c), 64'd1945);
    check("qbf_rsp_count", 64'(rv_count), 64'd1);
    check("qbf_rsp_data", 64'(rsp_data), 64'h12345678);

    // Back-to-back writes with req_valid held high
    wait_ready("b2b_ready1");
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_addr  = 8'h04;
    req_data  = 8'h80;
    @(negedge CLK);
    req_addr = 8'h01;
    req_data = 8'h13;
    wait_ready("b2b_ready2");
    @(negedge CLK);
    req_valid = 1'b0;
    wait_idle("b2b_idle");
    check_rec("b2b1", 16, 64'h0480);
    check_rec("b2b2", 16, 64'h0113);
    check("b2b_cs_gap", 64'(last_run), 64'd9);

    // Query pair: 0xBE -> all ones, 0xBF -> 1
    sl_word = 32'hFFFFFFFF;
    send(1'b1, 8'hBE, 8'h00);
    wait_idle("qbe_idle");
    check("qbe_rsp_data", 64'(rsp_data), 64'hFFFFFFFF);
    check("qbe_idle_sclk", 64'(spi_clk), 64'd0);
    sl_word = 32'h00000001;
    send(1'b1, 8'hBF, 8'h00);
    wait_idle("qbf1_idle");
    check("qbf1_rsp_data", 64'(rsp_data), 64'h00000001);
    check("qbf1_idle_sclk", 64'(spi_clk), 64'd0);
    recq.delete();

    // Reset at the 20th rising edge of a query
    sl_word = 32'hA5A5A5A5;
    send(1'b1, 8'hBF, 8'h00);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (sl_fid == fid && sl_edges == 20) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rst20_wait: 20th rising edge not seen, required within 4000 cycles");
    end
    rv0 = rv_count;
    RST = 1'b1;
    @(negedge CLK);
    check("rst20_cs", 64'(cs), 64'd1);
    check("rst20_spi_clk", 64'(spi_clk), 64'd0);
    check("rst20_busy", 64'(busy), 64'd0);
    check("rst20_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst20_rsp_data", 64'(rsp_data), 64'd0);
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_addr  = 8'h02;
    req_data  = 8'h07;
    @(negedge CLK);
    check("rst_with_req_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst20_no_rsp", 64'(rv_count), 64'(rv0));
    recq.delete();
    send(1'b0, 8'h02, 8'h07);
    wait_idle("w207_idle");
    check_rec("w207", 16, 64'h0207);

    // CLK_DIV=4 instance
    req_valid4 = 1'b1;
    req_addr4  = 8'h03;
    req_data4  = 8'h5A;
    @(negedge CLK);
    req_valid4 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (!busy4) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL div4_idle: busy=1 after 1000 cycles, required 0");
    end
    check("div4_bits", 64'(bits4), 64'h035A);
    check("div4_edges", 64'(cnt4), 64'd16);
    check("div4_toggles", 64'(tog4), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
